// File: rtl/monolith_axis_chunk_streamer_pkg.sv
// Shared types, width helper and statistics counter widths for the Monolith chunk streamer.
package monolith_axis_pkg;

   typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

   localparam int DROP_COUNT_W  = 16;
   localparam int STALL_COUNT_W = 32;

   // Index width for a counter over n positions; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/monolith_axis_chunk_streamer_if.sv
// AXI4-Stream bundle between the chunk streamer and the DMA S2MM channel.
interface monolith_axis_chunk_streamer_if #(
   parameter int TDATA_WIDTH = 32
);
   logic                     tvalid;
   logic [TDATA_WIDTH-1:0]   tdata;
   logic [TDATA_WIDTH/8-1:0] tstrb;
   logic                     tlast;
   logic                     tready;

   modport master (output tvalid, tdata, tstrb, tlast, input tready);
   modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/monolith_axis_chunk_streamer_out_reg.sv
// Registered AXIS output stage: holds one beat and tracks whether it is valid.
module monolith_axis_out_reg
   import monolith_axis_pkg::*;
#(
   parameter int TDATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   load,
   input  logic [TDATA_WIDTH-1:0] load_data,
   input  logic                   load_last,
   input  logic                   tready,
   output logic                   tvalid,
   output logic [TDATA_WIDTH-1:0] tdata,
   output logic                   tlast
);

   out_state_t state, state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OUT_EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // A consumed beat with nothing behind it empties the stage; flush always wins.
   always_comb begin
      state_next = state;
      case (state)
         OUT_EMPTY: if (load) state_next = OUT_FULL;
         OUT_FULL:  if (tready && !load) state_next = OUT_EMPTY;
      endcase
      if (flush) state_next = OUT_EMPTY;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tdata <= '0;
         tlast <= 1'b0;
      end else if (flush) begin
         tlast <= 1'b0;
      end else if (load) begin
         tdata <= load_data;
         tlast <= load_last;
      end
   end

   assign tvalid = (state == OUT_FULL);

endmodule

// File: rtl/monolith_axis_chunk_streamer.sv
// Chunk ring that serialises whole chunks into TLAST-framed AXIS packets.
// Define MONOLITH_AXIS_STATS_EN to add the drop_count/stall_count statistics outputs.
module monolith_axis_chunk_streamer
   import monolith_axis_pkg::*;
#(
   parameter int CHUNK_WORDS   = 16,
   parameter int CHUNK_COUNT   = 4,
   parameter int TDATA_WIDTH   = 32,
   parameter int PACKET_CHUNKS = 1
) (
   input  logic                               M_AXIS_ACLK,
   input  logic                               M_AXIS_ARESET,
   input  logic                               chunk_wr_strobe,
   input  logic [TDATA_WIDTH-1:0]             chunk_in [CHUNK_WORDS],
   output logic                               chunk_full,
   output logic [$clog2(CHUNK_COUNT+1)-1:0]   chunk_free,
   input  logic                               flush,
`ifdef MONOLITH_AXIS_STATS_EN
   output logic [DROP_COUNT_W-1:0]            drop_count,
   output logic [STALL_COUNT_W-1:0]           stall_count,
`endif
   monolith_axis_chunk_streamer_if.master     m_axis
);

   localparam int CHUNK_IDX_W = idx_width(CHUNK_COUNT);
   localparam int WORD_IDX_W  = idx_width(CHUNK_WORDS);
   localparam int PKT_IDX_W   = idx_width(PACKET_CHUNKS);
   localparam int OCC_W       = $clog2(CHUNK_COUNT + 1);

   typedef logic [CHUNK_IDX_W-1:0] chunk_idx_t;
   typedef logic [WORD_IDX_W-1:0]  word_idx_t;
   typedef logic [PKT_IDX_W-1:0]   pkt_idx_t;
   typedef logic [OCC_W-1:0]       occ_t;

   localparam chunk_idx_t LAST_CHUNK = chunk_idx_t'(CHUNK_COUNT - 1);
   localparam word_idx_t  LAST_WORD  = word_idx_t'(CHUNK_WORDS - 1);
   localparam pkt_idx_t   LAST_PKT   = pkt_idx_t'(PACKET_CHUNKS - 1);
   localparam occ_t       FULL_OCC   = occ_t'(CHUNK_COUNT);

   logic [TDATA_WIDTH-1:0] mem [CHUNK_COUNT][CHUNK_WORDS];

   chunk_idx_t wr_chunk, rd_chunk;
   word_idx_t  rd_word;
   pkt_idx_t   pkt_cnt;
   occ_t       occupancy;

   logic accept, load, retire, word_is_last, load_last;
   logic [TDATA_WIDTH-1:0] load_data;

   assign chunk_full   = (occupancy == FULL_OCC);
   assign chunk_free   = FULL_OCC - occupancy;
   assign accept       = chunk_wr_strobe && !chunk_full && !flush;
   assign load         = (!m_axis.tvalid || m_axis.tready) && (occupancy != '0) && !flush;
   assign word_is_last = (rd_word == LAST_WORD);
   assign retire       = load && word_is_last;
   assign load_last    = word_is_last && (pkt_cnt == LAST_PKT);
   assign load_data    = mem[rd_chunk][rd_word];

   // Storage is deliberately left unreset; occupancy alone says what is valid.
   always_ff @(posedge M_AXIS_ACLK) begin
      if (accept) mem[wr_chunk] <= chunk_in;
   end

   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         wr_chunk  <= '0;
         rd_chunk  <= '0;
         rd_word   <= '0;
         pkt_cnt   <= '0;
         occupancy <= '0;
      end else if (flush) begin
         wr_chunk  <= '0;
         rd_chunk  <= '0;
         rd_word   <= '0;
         pkt_cnt   <= '0;
         occupancy <= '0;
      end else begin
         if (accept) wr_chunk <= (wr_chunk == LAST_CHUNK) ? '0 : wr_chunk + 1'b1;
         if (load) begin
            if (word_is_last) begin
               rd_word  <= '0;
               rd_chunk <= (rd_chunk == LAST_CHUNK) ? '0 : rd_chunk + 1'b1;
               pkt_cnt  <= (pkt_cnt == LAST_PKT) ? '0 : pkt_cnt + 1'b1;
            end else begin
               rd_word <= rd_word + 1'b1;
            end
         end
         // Accept and retire in the same edge cancel out.
         case ({accept, retire})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
      end
   end

   monolith_axis_out_reg #(
      .TDATA_WIDTH(TDATA_WIDTH)
   ) u_out_reg (
      .clk       (M_AXIS_ACLK),
      .rst       (M_AXIS_ARESET),
      .flush     (flush),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .tready    (m_axis.tready),
      .tvalid    (m_axis.tvalid),
      .tdata     (m_axis.tdata),
      .tlast     (m_axis.tlast)
   );

   assign m_axis.tstrb = '1;

`ifdef MONOLITH_AXIS_STATS_EN
   // Drops saturate so a long overload stays visible; stalls wrap freely.
   always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
      if (M_AXIS_ARESET) begin
         drop_count  <= '0;
         stall_count <= '0;
      end else if (flush) begin
         drop_count  <= '0;
         stall_count <= '0;
      end else begin
         if (chunk_wr_strobe && chunk_full && (drop_count != '1)) drop_count <= drop_count + 1'b1;
         if (m_axis.tvalid && !m_axis.tready) stall_count <= stall_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_monolith_axis_chunk_streamer.sv
// Self-checking bench for monolith_axis_chunk_streamer: vector table, corner sequences, random traffic vs a word-queue model.
module tb_monolith_axis_chunk_streamer;

   localparam int CW     = 16;
   localparam int CC     = 3;
   localparam int DW     = 32;
   localparam int PC     = 2;
   localparam int FREE_W = $clog2(CC + 1);

   typedef struct {
      bit            strobe;
      logic [DW-1:0] base;
      bit            tready;
      bit            flush;
      bit            exp_valid;
      logic [DW-1:0] exp_data;
      bit            exp_last;
      int            exp_free;
      bit            exp_full;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              chunk_wr_strobe;
   logic [DW-1:0]     chunk_in [CW];
   logic              chunk_full;
   logic [FREE_W-1:0] chunk_free;
   logic              flush;
`ifdef MONOLITH_AXIS_STATS_EN
   logic [15:0]       drop_count;
   logic [31:0]       stall_count;
`endif

   monolith_axis_chunk_streamer_if #(.TDATA_WIDTH(DW)) axis ();

   monolith_axis_chunk_streamer #(
      .CHUNK_WORDS   (CW),
      .CHUNK_COUNT   (CC),
      .TDATA_WIDTH   (DW),
      .PACKET_CHUNKS (PC)
   ) dut (
      .M_AXIS_ACLK     (clk),
      .M_AXIS_ARESET   (rst),
      .chunk_wr_strobe (chunk_wr_strobe),
      .chunk_in        (chunk_in),
      .chunk_full      (chunk_full),
      .chunk_free      (chunk_free),
      .flush           (flush),
`ifdef MONOLITH_AXIS_STATS_EN
      .drop_count      (drop_count),
      .stall_count     (stall_count),
`endif
      .m_axis          (axis)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a queue of words not yet loaded plus one output slot.
   logic [DW-1:0] m_words [$];
   int            m_pending;
   bit            m_valid;
   logic [DW-1:0] m_data;
   bit            m_last;
   int            m_loaded;
   int            m_drop;
   int unsigned   m_stall;

   int            beat_no;
   int            last_beats [$];
   logic [DW-1:0] first_data;

   task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int model_occ();
      return (m_pending + CW - 1) / CW;
   endfunction

   task automatic model_reset();
      m_words.delete();
      m_pending = 0;
      m_valid   = 0;
      m_data    = '0;
      m_last    = 0;
      m_loaded  = 0;
      m_drop    = 0;
      m_stall   = 0;
      beat_no   = 0;
      last_beats.delete();
      first_data = '0;
   endtask

   task automatic model_step(input bit strobe, input logic [DW-1:0] base, input bit tready, input bit fl);
      int  occ = model_occ();
      bit  acc = strobe && (occ < CC) && !fl;
      bit  ld  = (!m_valid || tready) && (m_pending > 0) && !fl;
      if (fl) begin
         m_drop  = 0;
         m_stall = 0;
      end else begin
         if (strobe && occ == CC && m_drop < 16'hFFFF) m_drop++;
         if (m_valid && !tready) m_stall++;
      end
      if (fl) begin
         m_words.delete();
         m_pending = 0;
         m_valid   = 0;
         m_loaded  = 0;
      end else begin
         if (ld) begin
            m_data  = m_words.pop_front();
            m_last  = ((m_loaded + 1) % (CW * PC)) == 0;
            m_loaded++;
            m_valid = 1;
         end else if (tready) begin
            m_valid = 0;
         end
         if (acc) for (int i = 0; i < CW; i++) m_words.push_back(base + DW'(i));
         m_pending += (acc ? CW : 0) - (ld ? 1 : 0);
      end
   endtask

   task automatic compare_model();
      int occ = model_occ();
      check_output("tvalid", DW'(axis.tvalid), DW'(m_valid));
      if (m_valid) begin
         check_output("tdata", axis.tdata, m_data);
         check_output("tlast", DW'(axis.tlast), DW'(m_last));
      end
      check_output("chunk_free", DW'(chunk_free), DW'(CC - occ));
      check_output("chunk_full", DW'(chunk_full), DW'(occ == CC));
`ifdef MONOLITH_AXIS_STATS_EN
      check_output("drop_count", DW'(drop_count), DW'(m_drop));
      check_output("stall_count", stall_count, m_stall);
`endif
   endtask

   // Called at a negative edge; returns at the next negative edge after comparing.
   task automatic apply_stimulus(input bit strobe, input logic [DW-1:0] base, input bit tready, input bit fl);
      chunk_wr_strobe = strobe;
      for (int i = 0; i < CW; i++) chunk_in[i] = base + DW'(i);
      axis.tready = tready;
      flush       = fl;
      #1;
      if (axis.tvalid && tready && !fl) begin
         if (beat_no == 0) first_data = axis.tdata;
         if (axis.tlast) last_beats.push_back(beat_no);
         beat_no++;
      end
      @(posedge clk);
      model_step(strobe, base, tready, fl);
      if (fl) begin
         beat_no = 0;
         last_beats.delete();
      end
      @(negedge clk);
      compare_model();
   endtask

   task automatic drain(input int max_cycles);
      int cyc = 0;
      while ((m_valid || m_pending > 0) && cyc < max_cycles) begin
         apply_stimulus(0, '0, 1, 0);
         cyc++;
      end
      check_output("drain_timeout", DW'(m_valid || m_pending > 0), DW'(0));
   endtask

   task automatic check_last_at(input string name, input int idx, input int expected);
      check_output(name, (last_beats.size() > idx) ? DW'(last_beats[idx]) : DW'(-1), DW'(expected));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   vec_t vecs [5];

   initial begin
      vecs[0] = '{1, 32'h100, 1, 0, 0, 32'h0,   0, 2, 0};
      vecs[1] = '{1, 32'h200, 0, 0, 1, 32'h100, 0, 1, 0};
      vecs[2] = '{1, 32'h300, 0, 0, 1, 32'h100, 0, 0, 1};
      vecs[3] = '{1, 32'h400, 0, 0, 1, 32'h100, 0, 0, 1};
      vecs[4] = '{0, 32'h0,   1, 0, 1, 32'h101, 0, 0, 1};

      rst = 1'b1;
      chunk_wr_strobe = 1'b0;
      flush = 1'b0;
      axis.tready = 1'b0;
      for (int i = 0; i < CW; i++) chunk_in[i] = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_output("reset_tvalid", DW'(axis.tvalid), 0);
      check_output("reset_tlast", DW'(axis.tlast), 0);
      check_output("reset_tdata", axis.tdata, 0);
      check_output("reset_tstrb", DW'(axis.tstrb), DW'(4'hF));
      check_output("reset_free", DW'(chunk_free), DW'(CC));
      check_output("reset_full", DW'(chunk_full), 0);
      rst = 1'b0;

      // Fill to full with one dropped strobe, then release TREADY for one beat.
      for (int v = 0; v < 5; v++) begin
         apply_stimulus(vecs[v].strobe, vecs[v].base, vecs[v].tready, vecs[v].flush);
         check_output($sformatf("vec%0d_tvalid", v), DW'(axis.tvalid), DW'(vecs[v].exp_valid));
         if (vecs[v].exp_valid) begin
            check_output($sformatf("vec%0d_tdata", v), axis.tdata, vecs[v].exp_data);
            check_output($sformatf("vec%0d_tlast", v), DW'(axis.tlast), DW'(vecs[v].exp_last));
         end
         check_output($sformatf("vec%0d_free", v), DW'(chunk_free), DW'(vecs[v].exp_free));
         check_output($sformatf("vec%0d_full", v), DW'(chunk_full), DW'(vecs[v].exp_full));
      end
      drain(200);
      check_output("pkt1_beats", DW'(beat_no), 48);
      check_last_at("pkt1_last0", 0, 31);
      apply_stimulus(1, 32'h500, 1, 0);
      drain(100);
      check_output("pkt2_beats", DW'(beat_no), 64);
      check_last_at("pkt2_last1", 1, 63);
      check_output("pkt2_last_count", DW'(last_beats.size()), 2);

      // Strobe in the retire cycle of a full ring is rejected; the next one wraps to slot 0.
      apply_stimulus(0, '0, 0, 1);
      apply_stimulus(1, 32'h1000, 0, 0);
      apply_stimulus(1, 32'h2000, 0, 0);
      apply_stimulus(1, 32'h3000, 0, 0);
      check_output("ring_full", DW'(chunk_full), 1);
      repeat (14) apply_stimulus(0, '0, 1, 0);
      apply_stimulus(1, 32'h4000, 1, 0);
      check_output("retire_free", DW'(chunk_free), 1);
      apply_stimulus(1, 32'h5000, 1, 0);
      check_output("wrap_free", DW'(chunk_free), 0);
      drain(200);
      check_output("wrap_beats", DW'(beat_no), 64);

      // Random TREADY and write traffic.
      for (int c = 0; c < 400; c++)
         apply_stimulus($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 1) == 1, 0);
      drain(400);

      // Flush mid-stream, colliding with a write strobe.
      apply_stimulus(1, 32'h6000, 1, 0);
      repeat (5) apply_stimulus(0, '0, 1, 0);
      apply_stimulus(1, 32'h6100, 1, 1);
      check_output("flush_tvalid", DW'(axis.tvalid), 0);
      check_output("flush_free", DW'(chunk_free), DW'(CC));
      apply_stimulus(1, 32'h7000, 1, 0);
      apply_stimulus(1, 32'h8000, 1, 0);
      drain(100);
      check_output("flush_first", first_data, 32'h7000);
      check_output("flush_beats", DW'(beat_no), 32);
      check_last_at("flush_last0", 0, 31);

      // Asynchronous reset in the middle of a packet.
      apply_stimulus(1, 32'h9000, 1, 0);
      repeat (4) apply_stimulus(0, '0, 1, 0);
      #2 rst = 1'b1;
      chunk_wr_strobe = 1'b0;
      #1;
      check_output("areset_tvalid", DW'(axis.tvalid), 0);
      check_output("areset_tdata", axis.tdata, 0);
      check_output("areset_free", DW'(chunk_free), DW'(CC));
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1, 32'hA000, 1, 0);
      apply_stimulus(1, 32'hB000, 1, 0);
      drain(100);
      check_output("areset_first", first_data, 32'hA000);
      check_output("areset_beats", DW'(beat_no), 32);
      check_last_at("areset_last0", 0, 31);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/monolith_axis_chunk_streamer.md
# monolith_axis_chunk_streamer

Parametrised AXI4-Stream master that accepts whole data chunks in one cycle and serialises them one word per beat onto the M_AXIS port. It is the next generation of the Monolith chunk-write stream master and sits between the hash core's parallel output and the DMA S2MM channel. Compared with the previous generation it adds:
- a non-power-of-two chunk ring;
- a registered output stage;
- packet framing over a configurable number of chunks;
- a synchronous flush;
- optional drop/stall statistics.

## Interface
Parameters:
- CHUNK_WORDS, 16, words per chunk; ≥2.
- CHUNK_COUNT, 4, chunk slots in the ring; ≥2, any value (need not be a power of two).
- TDATA_WIDTH, 32, stream word width; a multiple of 8.
- PACKET_CHUNKS, 1, chunks per TLAST-delimited packet; ≥1.

Ports:
- M_AXIS_ACLK  in  1  the single clock.
- M_AXIS_ARESET  in  1  reset, asynchronous, active-high.
- chunk_wr_strobe  in  1  request to write chunk_in.
- chunk_in  in  CHUNK_WORDS x TDATA_WIDTH  unpacked chunk; element 0 is sent first.
- chunk_full  out  1  all CHUNK_COUNT slots are occupied.
- chunk_free  out  $clog2(CHUNK_COUNT+1)  number of free slots.
- flush  in  1  synchronous clear of all stored data.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TDATA  out  TDATA_WIDTH  beat data.
- M_AXIS_TSTRB  out  TDATA_WIDTH/8  all ones.
- M_AXIS_TLAST  out  1  last beat of a packet.
- M_AXIS_TREADY  in  1  downstream ready.

## Operation
- Ring storage: CHUNK_COUNT slots of CHUNK_WORDS words each.
  - wr_chunk and rd_chunk wrap explicitly from CHUNK_COUNT-1 to 0.
  - rd_word runs 0..CHUNK_WORDS-1 within the head slot.
- Write: accepted iff chunk_wr_strobe & !chunk_full & !flush. All words of the slot are stored in one edge, then wr_chunk advances.
  - A strobe while full is silently dropped. The slot freed in that same cycle does not make the write acceptable (no same-cycle bypass).
- Occupancy: number of slots holding unsent words.
  - A slot is retired on the edge its last word is loaded into the output register.
  - Simultaneous accept and retire leaves occupancy unchanged.
  - chunk_free = CHUNK_COUNT − occupancy.
- Output register: a two-state machine.
  - EMPTY: TVALID=0. Go to FULL when occupancy>0.
  - FULL: TVALID=1.
    - On TREADY with occupancy>0: load the next word and stay in FULL.
    - On TREADY with occupancy==0: go to EMPTY.
    - Without TREADY: hold.
- Load condition: (!TVALID | TREADY) & occupancy>0. Throughput is one beat per cycle.
- Framing: pkt_cnt counts retired chunks modulo PACKET_CHUNKS. The TLAST register is set with the loaded word iff rd_word==CHUNK_WORDS-1 and pkt_cnt==PACKET_CHUNKS-1.
  - TLAST does not depend on how full the ring is.
- Flush:
  - Clears occupancy, all pointers, pkt_cnt and TVALID on the next edge.
  - Takes priority over a write in the same cycle.
  - Breaks AXIS hold rules by design; assert it only with downstream idle or in reset.
- Memory contents are not reset.

## Timing
- Reset values: TVALID=0, TLAST=0, TDATA=0, chunk_full=0, chunk_free=CHUNK_COUNT. All pointers and pkt_cnt are 0.
- Latency: a chunk accepted at edge N with the output stage EMPTY gives TVALID=1 with word 0 after edge N+1.
- While TVALID=1 & TREADY=0, TDATA and TLAST are stable.
- chunk_full and chunk_free are registered-state derived, with no combinational path from TREADY.
- Reset mid-packet: everything returns to reset values immediately (asynchronous); there is no partial-packet recovery.
- Pointer wrap: CHUNK_COUNT=3 gives slot sequence 0,1,2,0.

## Configuration
- MONOLITH_AXIS_STATS_EN defined:
  - Adds output drop_count (16 bit): increments on each rejected strobe while full, and saturates at 0xFFFF.
  - Adds output stall_count (32 bit): increments each cycle with TVALID & !TREADY, and wraps.
  - Both counters are cleared by reset and by flush.
- Not defined: neither port nor their logic exists; behaviour is otherwise identical.

## Structure
- Package monolith_axis_pkg holds:
  - the chunk-index and word-index typedef helpers;
  - output-state enum {OUT_EMPTY, OUT_FULL};
  - STATS counter widths as localparams.
- Sub-module monolith_axis_out_reg: the output register and state machine, parametrised on TDATA_WIDTH. It takes load/data/last inputs and drives the AXIS outputs.

## Test plan
- Write one chunk of 0..15, TREADY=1 held → 16 beats of 0..15 on consecutive cycles, TVALID first high one cycle after the write, TLAST only on beat 15.
- CHUNK_COUNT=3: write 4 chunks back-to-back with TREADY=0 → 3 accepted, chunk_full=1, chunk_free=0, 4th dropped (drop_count=1 with STATS). Release TREADY → 48 beats in order.
- TREADY toggled randomly → TDATA/TLAST stable during every stall, no beat lost or duplicated, stall_count equals the number of TVALID & !TREADY cycles.
- PACKET_CHUNKS=2, write 4 chunks → TLAST on beats 31 and 63 only.
- Ring full, with a write strobe arriving in the retire cycle of the head slot → write rejected. The next strobe is accepted, and the slot index wraps 2→0.
- Flush mid-stream, then assert reset mid-packet → TVALID=0 next edge (flush) or immediately (reset), chunk_free=CHUNK_COUNT. A new chunk afterwards streams from word 0 with pkt_cnt restarted.
